// File: rtl/wb_sram_burst_pkg.sv
// rtl/wb_sram_burst_pkg.sv - shared FSM encodings and bus constants for the SRAM burst reader
// Contents:
//   ST_IDLE..ST_FLUSH  2-bit state encodings of the burst FSM
//   state_t            enumerated FSM state type built on those encodings
//   WB_WE_READ         write-enable level driven during read cycles
package wb_sram_burst_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN,
        FLUSH = ST_FLUSH
    } state_t;

    // This master only ever reads.
    localparam logic WB_WE_READ = 1'b0;

endpackage

// File: rtl/wb_fifo_fwft.sv
// rtl/wb_fifo_fwft.sv - synchronous first-word-fall-through FIFO with occupancy count
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   push          write push_data on this edge
//   push_data     word to store
//   pop           consume the head word on this edge
//   head          current head word (valid while valid is high)
//   valid         FIFO holds at least one word
//   count         number of stored words, 0 to 1<<FBITS
module wb_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int FBITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [FBITS:0]   count
);

    localparam int DEPTH = 1 << FBITS;
    localparam logic [FBITS:0]   CNT_ONE = 1;
    localparam logic [FBITS-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [FBITS-1:0] rd_ptr;
    logic [FBITS-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign valid = (count != '0);
    assign full  = (count == (FBITS+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // A push into a full FIFO is still legal when the head leaves on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && valid;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_sram_burst_reader.sv
// rtl/wb_sram_burst_reader.sv - pipelined Wishbone burst read master feeding a valid/ready stream
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   start_i, base_i, len_i  command: read len_i words starting at base_i (sampled when idle)
//   busy_o, done_o          command in progress / one-cycle completion pulse
//   cyc_o, stb_o, we_o,     Wishbone master request side; bst_o flags more strobes to follow
//   bst_o, adr_o
//   ack_i, dat_i            Wishbone acknowledge and read data (ack one cycle after strobe)
//   valid_o, ready_i,       output word stream, first-word fall-through from a small FIFO
//   data_o
module wb_sram_burst_reader
    import wb_sram_burst_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MSB   = WIDTH - 1,
    parameter int SBITS = 10,
    parameter int ASB   = SBITS - 1,
    parameter int FBITS = 2,
    parameter int DELAY = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [ASB:0] base_i,
    input  logic [SBITS:0] len_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         cyc_o,
    output logic         stb_o,
    output logic         we_o,
    output logic         bst_o,
    output logic [ASB:0] adr_o,
    input  logic         ack_i,
    input  logic [MSB:0] dat_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [MSB:0] data_o
);

    // DELAY only models output skew in simulation; the synthesised logic has none.
    if (DELAY < 0) begin : g_delay_range
    end

    localparam logic [SBITS:0]   CNT_ONE = 1;
    localparam logic [ASB:0]     ADR_ONE = 1;
    localparam logic [SBITS+1:0] DEPTH_W = (SBITS+2)'(1 << FBITS);

    state_t         state;
    state_t         state_next;
    logic [ASB:0]   adr;
    logic [SBITS:0] req_left;
    logic [SBITS:0] outstanding;
    logic           done_r;
    logic           done_next;
    logic           load;
    logic           stb;
    logic           cyc;
    logic           ack_acc;
    logic           ack_dec;
    logic           pop;

    logic [MSB:0]   fifo_head;
    logic           fifo_valid;
    logic [FBITS:0] fifo_count;

    logic [SBITS+1:0] in_flight;
    logic [SBITS+1:0] credit_limit;

    wb_fifo_fwft #(
        .WIDTH (WIDTH),
        .FBITS (FBITS)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (ack_acc),
        .push_data (dat_i),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign pop     = fifo_valid && ready_i;
    assign cyc     = (state == ISSUE) || (state == DRAIN);
    assign ack_acc = ack_i && cyc;
    assign ack_dec = ack_acc && (outstanding != '0);

    // Every word already buffered or still on the bus owns a FIFO slot; a pop on
    // this edge frees one, so the limit grows by one in that cycle.
    assign in_flight    = (SBITS+2)'(fifo_count) + (SBITS+2)'(outstanding);
    assign credit_limit = DEPTH_W + (SBITS+2)'(pop);

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        load       = 1'b0;
        stb        = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                stb = (in_flight < credit_limit);
                if (stb && (req_left == CNT_ONE)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding == '0) || ((outstanding == CNT_ONE) && ack_acc)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!fifo_valid) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            adr         <= '0;
            req_left    <= '0;
            outstanding <= '0;
            done_r      <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= done_next;
            if (load) begin
                adr      <= base_i;
                req_left <= len_i;
            end else if (stb) begin
                // Natural overflow of the SBITS-wide counter gives the wrap to 0.
                adr      <= adr + ADR_ONE;
                req_left <= req_left - CNT_ONE;
            end
            case ({stb, ack_dec})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign busy_o  = (state != IDLE);
    assign done_o  = done_r;
    assign cyc_o   = cyc;
    assign stb_o   = stb;
    assign we_o    = WB_WE_READ;
    assign bst_o   = cyc && (req_left > CNT_ONE);
    assign adr_o   = adr;
    assign valid_o = fifo_valid;
    // Hold the stream bus at zero while empty so stale RAM contents never show.
    assign data_o  = fifo_valid ? fifo_head : '0;

endmodule

// File: tb/tb_wb_sram_burst_reader.sv
// tb/tb_wb_sram_burst_reader.sv - randomized self-checking bench for wb_sram_burst_reader
module tb_wb_sram_burst_reader;

    localparam int WIDTH = 32;
    localparam int SBITS = 10;
    localparam int AW    = 1 << SBITS;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [SBITS-1:0] base_i;
    logic [SBITS:0]   len_i;
    logic             busy_o, done_o, cyc_o, stb_o, we_o, bst_o;
    logic [SBITS-1:0] adr_o;
    logic             ack_i = 1'b0;
    logic [WIDTH-1:0] dat_i = '0;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;

    always #5 clk = ~clk;

    wb_sram_burst_reader #(.WIDTH(WIDTH), .SBITS(SBITS), .FBITS(2)) dut (
        .clk_i (clk), .rst_i (rst_i), .start_i (start_i), .base_i (base_i), .len_i (len_i),
        .busy_o (busy_o), .done_o (done_o), .cyc_o (cyc_o), .stb_o (stb_o), .we_o (we_o),
        .bst_o (bst_o), .adr_o (adr_o), .ack_i (ack_i), .dat_i (dat_i),
        .valid_o (valid_o), .ready_i (ready_i), .data_o (data_o)
    );

    // SRAM slave: pipelined, acks one cycle after each strobe, never stalls.
    logic [WIDTH-1:0] mem [AW];
    always @(posedge clk) begin
        ack_i <= cyc_o && stb_o;
        dat_i <= mem[adr_o];
    end

    int checks = 0;
    int errors = 0;

    // Observation of the bus and stream, sampled on the falling edge.
    logic [WIDTH-1:0] got_q[$];
    logic [SBITS-1:0] adr_q[$];
    logic             bst_q[$];
    int cyc_cnt = 0, pop_first, pop_last, done_cnt, done_got, cyc_falls, stall_err, over_err, pending;
    logic cyc_seen, prev_v, prev_r, prev_rst, prev_cyc;
    logic [WIDTH-1:0] prev_d;

    always @(negedge clk) begin
        cyc_cnt++;
        if (valid_o && ready_i) begin
            if (got_q.size() == 0) pop_first = cyc_cnt;
            pop_last = cyc_cnt;
            got_q.push_back(data_o);
            pending--;
        end
        if (cyc_o && stb_o) begin
            adr_q.push_back(adr_o);
            bst_q.push_back(bst_o);
            pending++;
        end
        if (pending > 4) over_err++;
        if (done_o) begin
            done_cnt++;
            done_got = got_q.size();
        end
        if (cyc_o) cyc_seen = 1'b1;
        if (prev_cyc && !cyc_o) cyc_falls++;
        if (prev_v && !prev_r && !prev_rst && !rst_i && !(valid_o && data_o === prev_d)) stall_err++;
        prev_v   = valid_o;
        prev_r   = ready_i;
        prev_rst = rst_i;
        prev_cyc = cyc_o;
        prev_d   = data_o;
    end

    task automatic clear_mon();
        got_q.delete(); adr_q.delete(); bst_q.delete();
        done_cnt = 0; done_got = 0; cyc_falls = 0; stall_err = 0; over_err = 0; pending = 0;
        pop_first = 0; pop_last = 0; cyc_seen = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < AW; i++) mem[i] = $urandom;
    endtask

    task automatic issue_cmd(input logic [SBITS-1:0] b, input logic [SBITS:0] l);
        @(posedge clk); #1;
        start_i = 1'b1; base_i = b; len_i = l;
        @(posedge clk); #1;
        start_i = 1'b0; base_i = SBITS'($urandom); len_i = (SBITS+1)'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rand_ready, input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            if (done_o) begin ok = 1'b1; break; end
        end
        ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s done_timeout: no done_o within %0d cycles", tag, budget); end
    endtask

    // Reference: a command of length l yields words mem[(b+i) mod AW] at addresses (b+i) mod AW,
    // bst high on every strobe except the last, one done pulse after all words are popped.
    task automatic check_stream(input logic [SBITS-1:0] b, input int l, input string tag);
        int bad;
        int idx;
        checks++;
        if (got_q.size() != l) begin errors++; $display("FAIL %s word_count: got %0d expected %0d", tag, got_q.size(), l); end
        bad = -1;
        for (int i = 0; i < got_q.size() && i < l; i++) begin
            idx = (int'(b) + i) % AW;
            if (got_q[i] !== mem[idx]) begin bad = i; break; end
        end
        checks++;
        if (bad >= 0) begin
            idx = (int'(b) + bad) % AW;
            errors++; $display("FAIL %s data_seq: index %0d got %h expected %h", tag, bad, got_q[bad], mem[idx]);
        end
        checks++;
        if (adr_q.size() != l) begin errors++; $display("FAIL %s strobe_count: got %0d expected %0d", tag, adr_q.size(), l); end
        bad = -1;
        for (int i = 0; i < adr_q.size() && i < l; i++) begin
            if (int'(adr_q[i]) != (int'(b) + i) % AW || bst_q[i] !== (i != l - 1)) begin bad = i; break; end
        end
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL %s adr_bst_seq: index %0d got adr %h bst %b expected adr %h bst %b",
                               tag, bad, adr_q[bad], bst_q[bad], (int'(b) + bad) % AW, (bad != l - 1));
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt); end
        checks++;
        if (done_got != l) begin errors++; $display("FAIL %s done_after_pops: got %0d pops expected %0d", tag, done_got, l); end
        checks++;
        if (cyc_falls != 1) begin errors++; $display("FAIL %s cyc_continuous: got %0d falls expected 1", tag, cyc_falls); end
        checks++;
        if (stall_err != 0) begin errors++; $display("FAIL %s data_hold: got %0d unstable cycles expected 0", tag, stall_err); end
        checks++;
        if (over_err != 0) begin errors++; $display("FAIL %s credit_limit: got %0d overruns expected 0", tag, over_err); end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; base_i = 10'h005; len_i = 11'd4; ready_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy_o, done_o, cyc_o, stb_o, we_o, bst_o, valid_o} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {busy_o, done_o, cyc_o, stb_o, we_o, bst_o, valid_o});
        end
        checks++;
        if (adr_o !== '0 || data_o !== '0) begin errors++; $display("FAIL reset_buses: got adr %h data %h expected 0 0", adr_o, data_o); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy_o, cyc_o, stb_o} !== 3'b0) begin errors++; $display("FAIL reset_hold: got %b expected 000", {busy_o, cyc_o, stb_o}); end
        start_i = 1'b0; rst_i = 1'b0;
        clear_mon();
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || cyc_seen || done_cnt != 0) begin
            errors++; $display("FAIL reset_start_ignored: got busy %b cyc_seen %b done %0d expected 0 0 0", busy_o, cyc_seen, done_cnt);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < AW; i++) mem[i] = i;
        ready_i = 1'b1;
        clear_mon();
        issue_cmd(10'h3FE, 11'd5);
        checks++;
        if (stb_o !== 1'b1 || busy_o !== 1'b1 || adr_o !== 10'h3FE) begin
            errors++; $display("FAIL lat_stb: got stb %b busy %b adr %h expected 1 1 3fe", stb_o, busy_o, adr_o);
        end
        @(posedge clk); #1;
        checks++;
        if (ack_i !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL lat_ack: got ack %b valid %b expected 1 0", ack_i, valid_o); end
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h3FE) begin errors++; $display("FAIL lat_valid: got valid %b data %h expected 1 3fe", valid_o, data_o); end
        wait_done(50, 1'b0, "wrap");
        check_stream(10'h3FE, 5, "wrap");
        checks++;
        if (pop_last - pop_first != 4) begin errors++; $display("FAIL wrap_throughput: got %0d cycles expected 4", pop_last - pop_first); end
    endtask

    task automatic test_backpressure();
        logic [SBITS-1:0] b;
        fill_random();
        b = SBITS'($urandom);
        ready_i = 1'b0;
        clear_mon();
        issue_cmd(b, 11'd10);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (adr_q.size() != 4) begin errors++; $display("FAIL bp_strobes: got %0d expected 4", adr_q.size()); end
        checks++;
        if ({stb_o, cyc_o, bst_o, valid_o} !== 4'b0111) begin
            errors++; $display("FAIL bp_stall: got stb/cyc/bst/valid %b expected 0111", {stb_o, cyc_o, bst_o, valid_o});
        end
        wait_done(300, 1'b1, "bp");
        check_stream(b, 10, "bp");
    endtask

    task automatic test_zero_single();
        logic [SBITS-1:0] b;
        ready_i = 1'b1;
        clear_mon();
        issue_cmd(SBITS'($urandom), 11'd0);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL zero_done: got done %b busy %b expected 1 0", done_o, busy_o); end
        @(posedge clk); #1;
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: got %b expected 0", done_o); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (cyc_seen || adr_q.size() != 0) begin errors++; $display("FAIL zero_no_bus: got cyc_seen %b strobes %0d expected 0 0", cyc_seen, adr_q.size()); end
        fill_random();
        b = SBITS'($urandom);
        clear_mon();
        issue_cmd(b, 11'd1);
        wait_done(50, 1'b1, "single");
        check_stream(b, 1, "single");
    endtask

    task automatic test_ignore_start();
        logic [SBITS-1:0] b;
        fill_random();
        b = SBITS'($urandom);
        ready_i = 1'b1;
        clear_mon();
        issue_cmd(b, 11'd8);
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b1; base_i = b + 10'd100; len_i = 11'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_done(200, 1'b1, "ignore");
        check_stream(b, 8, "ignore");
    endtask

    task automatic test_reset_mid();
        logic [SBITS-1:0] b;
        int acks = 0;
        int l;
        fill_random();
        ready_i = 1'b1;
        clear_mon();
        issue_cmd(SBITS'($urandom), 11'd8);
        for (int c = 0; c < 20; c++) begin
            if (ack_i === 1'b1) acks++;
            if (acks == 3) break;
            @(posedge clk); #1;
        end
        checks++;
        if (acks != 3) begin errors++; $display("FAIL mid_third_ack: got %0d acks expected 3", acks); end
        rst_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cyc_o, stb_o, valid_o, busy_o} !== 4'b0) begin
            errors++; $display("FAIL mid_abort: got cyc/stb/valid/busy %b expected 0000", {cyc_o, stb_o, valid_o, busy_o});
        end
        rst_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt); end
        b = SBITS'($urandom);
        l = $urandom_range(1, 20);
        clear_mon();
        issue_cmd(b, (SBITS+1)'(l));
        wait_done(300, 1'b1, "after_mid");
        check_stream(b, l, "after_mid");
    endtask

    task automatic test_random();
        logic [SBITS-1:0] b;
        int l;
        for (int k = 0; k < 4; k++) begin
            fill_random();
            b = SBITS'($urandom);
            l = (k == 0) ? AW : $urandom_range(1, 40);
            clear_mon();
            issue_cmd(b, (SBITS+1)'(l));
            wait_done(l * 8 + 100, 1'b1, "random");
            check_stream(b, l, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < AW; i++) mem[i] = '0;
        clear_mon();
        test_reset();
        test_wrap();
        test_backpressure();
        test_zero_single();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_sram_burst_reader.md
Name: wb_sram_burst_reader

Overview:
- Pipelined Wishbone read master that sits directly upstream of the single-port SRAM slave.
- On a start command it fetches a block of words from SRAM as one burst, buffers them in a small FIFO, and presents them on a valid/ready stream. The stream feeds the downstream readout and transmit logic.
- Flow control uses credits, so every acknowledged word always has FIFO space. There is no slave stall signal.

Parameters:
- WIDTH, 32, data word width
- MSB, WIDTH-1, data MSB index
- SBITS, 10, SRAM address bits
- ASB, SBITS-1, address MSB index
- FBITS, 2, log2 of the FIFO depth (depth = 4)
- DELAY, 3, simulation-only intra-assignment delay on registered outputs

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start-command strobe; sampled only when idle
- base_i  in  SBITS  first SRAM address
- len_i  in  SBITS+1  word count, 0 to 1<<SBITS
- busy_o  out  1  high while a command is in progress
- done_o  out  1  one-cycle pulse when the command completes
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable; constant 0
- bst_o  out  1  burst indicator
- adr_o  out  SBITS  Wishbone address
- ack_i  in  1  Wishbone acknowledge
- dat_i  in  WIDTH  Wishbone read data
- valid_o  out  1  stream data valid
- ready_i  in  1  stream ready (downstream accepts)
- data_o  out  WIDTH  stream data

Behaviour:
- Reset state: all outputs 0 one edge after rst_i is sampled high; FIFO empty; FSM = IDLE.
- Reset mid-operation aborts the burst. cyc_o and stb_o drop on that edge. Buffered data is discarded. done_o does not pulse.
- Slave model: pipelined, no stall. The ack for a strobe sampled at edge k arrives high after edge k+1, with dat_i valid in the same cycle.
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - start_i with len_i>0: latch base_i and len_i; go to ISSUE; busy_o=1.
  - start_i with len_i=0: done_o pulses for one cycle at the next edge; no bus activity.
- ISSUE:
  - cyc_o=1.
  - stb_o=1 when (fifo_count + outstanding) < depth. Count the slot freed by a same-cycle pop; no other credit is borrowed.
  - adr_o increments modulo 1<<SBITS after each issued strobe, so addresses wrap from (1<<SBITS)-1 to 0.
  - Leave for DRAIN on the edge that issues the last strobe.
- DRAIN: cyc_o=1, stb_o=0. Wait for outstanding=0, then drop cyc_o on the edge of the final ack and go to FLUSH.
- FLUSH: wait until the FIFO is empty, then pulse done_o, drop busy_o and return to IDLE.
- bst_o = cyc_o && (requests_left > 1).
  - It is high from the first strobe and low during the cycle the final strobe is issued, i.e. one cycle before the final ack.
  - A single-word command never asserts bst_o.
- cyc_o stays high continuously from the first strobe to the final ack, including credit stalls.
- Every ack_i writes dat_i into the FIFO on the same edge. An ack arriving when cyc_o=0 is ignored.
- Stream rules:
  - valid_o = FIFO not empty; data_o = FIFO head (first-word fall-through).
  - A pop occurs on the edge where valid_o && ready_i.
  - data_o must hold stable while valid_o && !ready_i.
- Simultaneous FIFO push and pop: count unchanged, and both operations take effect.
- Latency: start_i sampled at edge n gives stb_o high after n, ack after n+1, and valid_o high after n+2.
- Throughput: with ready_i held high, one word per cycle is sustained after the first word.
- start_i while busy_o=1 is ignored; the latched command is unaffected.
- Counter widths: requests_left and outstanding use SBITS+1 bits, and len_i = 1<<SBITS is legal.

Decomposition:
- Package wb_sram_burst_pkg holds:
  - the FSM state encodings (ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FLUSH) as 2-bit localparams;
  - the bus-cycle helper constants.
- One sub-module: wb_fifo_fwft, a parameterised (WIDTH, FBITS) synchronous first-word-fall-through FIFO with a count output, reset by rst_i.
- The FSM, address counter and credit logic stay in the top module.

Test Plan:
- Reset: hold rst_i for 3 cycles. Every output is 0, and a start_i pulse during reset is ignored.
- Wrap: SRAM preloaded with mem[a]=a, base_i=0x3FE, len_i=5, ready_i=1.
  - adr_o sequence is 3FE, 3FF, 000, 001, 002; data_o sequence is 3FE, 3FF, 0, 1, 2.
  - bst_o is low only on the 5th strobe; done_o pulses once after the 5th pop.
- Backpressure: len_i=10, ready_i=0.
  - Exactly 4 strobes are issued, then stb_o=0 while cyc_o stays 1.
  - Release ready_i: all 10 words arrive in order, none lost or duplicated.
- Zero and single: len_i=0 gives done_o one cycle later and cyc_o never asserts. len_i=1 gives one strobe with bst_o=0.
- start_i pulsed mid-burst with a different base_i is ignored; the output matches the first command.
- Reset asserted during the 3rd ack of an 8-word burst: cyc_o, stb_o and valid_o are 0 after that edge, there is no done_o pulse, and the next command runs correctly.
